// File: rtl/ls193_drv_pkg.sv
// Shared types for the LS193 pulse driver: command opcodes, FSM states and
// timer sizing, used by the RTL, the bench and any caller.
package ls193_drv_pkg;

   typedef enum logic [1:0] {
      OP_CLR  = 2'b00,
      OP_LOAD = 2'b01,
      OP_UP   = 2'b10,
      OP_DOWN = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLR_ON   = 3'd1,
      LD_SETUP = 3'd2,
      LD_ON    = 3'd3,
      LD_HOLD  = 3'd4,
      P_LOW    = 3'd5,
      P_HIGH   = 3'd6,
      FIN      = 3'd7
   } state_t;

   localparam int TMR_W = 8;

   // States whose duration is set by the phase timer
   function automatic logic is_timed(state_t s);
      case (s)
         CLR_ON, LD_ON, P_LOW, P_HIGH: is_timed = 1'b1;
         default:                      is_timed = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ls193_pulse_driver_if.sv
// Command/status bus between a game-logic master and the LS193 pulse driver.
interface ls193_pulse_driver_if #(
   parameter int WIDTH = 8
);
   import ls193_drv_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   op_t              cmd_op;
   logic [WIDTH-1:0] cmd_arg;
   logic             busy;
   logic             done;
   logic [7:0]       wraps;

   modport master (
      output cmd_valid, cmd_op, cmd_arg,
      input  cmd_ready, busy, done, wraps
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg,
      output cmd_ready, busy, done, wraps
   );

endinterface

// File: rtl/ls193_pulse_timer.sv
// Loadable phase down-counter: after a load of len, expire pulses high for one
// cycle in the len-th cycle, so a state loaded on entry lasts exactly len cycles.
module ls193_pulse_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] len,
   output logic         expire
);

   logic [W-1:0] cnt_r;
   logic         active_r;

   assign expire = active_r && (cnt_r == {W{1'b0}});

   // Phase counter; a new load overrides a pending expiry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= {W{1'b0}};
         active_r <= 1'b0;
      end else if (load) begin
         cnt_r    <= len - {{(W-1){1'b0}}, 1'b1};
         active_r <= 1'b1;
      end else if (expire) begin
         active_r <= 1'b0;
      end else if (cnt_r != {W{1'b0}}) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/ls193_pulse_driver.sv
// Command-driven pin sequencer for an LS193 up/down counter; also counts the
// carry/borrow pulses it returns so cascaded counters can be tracked.
module ls193_pulse_driver #(
   parameter int WIDTH      = 8,
   parameter int PULSE_LOW  = 2,
   parameter int PULSE_HIGH = 2,
   parameter int CLR_CYC    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ls193_pulse_driver_if.slave  cmd,
   output logic                 clr,
   output logic                 load_n,
   output logic                 up_n,
   output logic                 down_n,
   output logic                 a,
   output logic                 b,
   output logic                 c,
   output logic                 d,
   input  logic                 co_n,
   input  logic                 bo_n
);
   import ls193_drv_pkg::*;

   localparam logic [TMR_W-1:0] LEN_LOW  = TMR_W'(PULSE_LOW);
   localparam logic [TMR_W-1:0] LEN_HIGH = TMR_W'(PULSE_HIGH);
   localparam logic [TMR_W-1:0] LEN_CLR  = TMR_W'(CLR_CYC);
   localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_r, state_nxt_s;
   op_t              op_r, op_sel_s;
   logic [WIDTH-1:0] rem_r;
   logic             ready_r, busy_r, done_r;
   logic [7:0]       wraps_r;
   logic             co_r, co_d_r, bo_r, bo_d_r;

   logic             accept_s, rem_dec_s, tmr_load_s, tmr_expire_s, wrap_inc_s;
   logic [TMR_W-1:0] tmr_len_s;

   assign accept_s  = cmd.cmd_valid && ready_r;
   assign op_sel_s  = accept_s ? cmd.cmd_op : op_r;

   assign cmd.cmd_ready = ready_r;
   assign cmd.busy      = busy_r;
   assign cmd.done      = done_r;
   assign cmd.wraps     = wraps_r;

   ls193_pulse_timer #(.W(TMR_W)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load_s),
      .len    (tmr_len_s),
      .expire (tmr_expire_s)
   );

   // Next-state logic; the timer is reloaded on every entry into a timed state
   always_comb begin
      state_nxt_s = state_r;
      rem_dec_s   = 1'b0;
      tmr_load_s  = 1'b0;
      tmr_len_s   = {TMR_W{1'b0}};
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               case (cmd.cmd_op)
                  OP_CLR:  state_nxt_s = CLR_ON;
                  OP_LOAD: state_nxt_s = LD_SETUP;
                  OP_UP, OP_DOWN: begin
                     if (cmd.cmd_arg == {WIDTH{1'b0}}) begin
                        state_nxt_s = FIN;
                     end else begin
                        state_nxt_s = P_LOW;
                     end
                  end
                  default: state_nxt_s = IDLE;
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CLR_ON:   state_nxt_s = tmr_expire_s ? FIN : CLR_ON;
         LD_SETUP: state_nxt_s = LD_ON;
         LD_ON:    state_nxt_s = tmr_expire_s ? LD_HOLD : LD_ON;
         LD_HOLD:  state_nxt_s = FIN;
         P_LOW:    state_nxt_s = tmr_expire_s ? P_HIGH : P_LOW;
         P_HIGH: begin
            if (tmr_expire_s) begin
               rem_dec_s   = 1'b1;
               state_nxt_s = (rem_r == ONE_W) ? FIN : P_LOW;
            end else begin
               state_nxt_s = P_HIGH;
            end
         end
         FIN:      state_nxt_s = IDLE;
         default:  state_nxt_s = IDLE;
      endcase

      if ((state_nxt_s != state_r) && is_timed(state_nxt_s)) begin
         tmr_load_s = 1'b1;
         case (state_nxt_s)
            CLR_ON:  tmr_len_s = LEN_CLR;
            P_HIGH:  tmr_len_s = LEN_HIGH;
            default: tmr_len_s = LEN_LOW;
         endcase
      end else begin
         tmr_load_s = 1'b0;
      end
   end

   // FSM state, command capture and handshake status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         op_r    <= OP_CLR;
         rem_r   <= {WIDTH{1'b0}};
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         op_r    <= op_sel_s;
         if (accept_s) begin
            rem_r <= cmd.cmd_arg;
         end else if (rem_dec_s) begin
            rem_r <= rem_r - ONE_W;
         end else begin
            rem_r <= rem_r;
         end
         // Ready comes back only once the FIN-driven DONE cycle has passed
         ready_r <= (state_r == IDLE) && !accept_s;
         busy_r  <= !((state_r == IDLE) && !accept_s);
         done_r  <= (state_r == FIN);
      end
   end

   // Pin registers follow the next state so pins line up with the state they belong to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr          <= 1'b0;
         load_n       <= 1'b1;
         up_n         <= 1'b1;
         down_n       <= 1'b1;
         {d, c, b, a} <= 4'b0000;
      end else begin
         clr    <= (state_nxt_s == CLR_ON);
         load_n <= (state_nxt_s != LD_ON);
         up_n   <= !((state_nxt_s == P_LOW) && (op_sel_s == OP_UP));
         down_n <= !((state_nxt_s == P_LOW) && (op_sel_s == OP_DOWN));
         if (accept_s && (cmd.cmd_op == OP_LOAD)) begin
            {d, c, b, a} <= cmd.cmd_arg[3:0];
         end else begin
            {d, c, b, a} <= {d, c, b, a};
         end
      end
   end

   assign wrap_inc_s = (co_d_r && !co_r) || (bo_d_r && !bo_r);

   // Carry/borrow fall detection and saturating wrap counter; CLR wins over an increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         co_r    <= 1'b1;
         co_d_r  <= 1'b1;
         bo_r    <= 1'b1;
         bo_d_r  <= 1'b1;
         wraps_r <= 8'd0;
      end else begin
         co_r   <= co_n;
         co_d_r <= co_r;
         bo_r   <= bo_n;
         bo_d_r <= bo_r;
         if (accept_s && (cmd.cmd_op == OP_CLR)) begin
            wraps_r <= 8'd0;
         end else if (wrap_inc_s && (wraps_r != 8'hFF)) begin
            wraps_r <= wraps_r + 8'd1;
         end else begin
            wraps_r <= wraps_r;
         end
      end
   end

endmodule
